// File: rtl/sine_ctrl_pkg.sv
// Shared types and helpers for the sine-sum sweep sequencer.
package sine_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DWELL, PAUSED} state_t;

    localparam int DELTA_W = 12;
    localparam logic [DELTA_W-1:0] DELTA_MAX = 12'hFFF;

    // Unsigned add that sticks at DELTA_MAX instead of wrapping.
    function automatic logic [DELTA_W-1:0] sat_add(input logic [DELTA_W-1:0] a,
                                                   input logic [DELTA_W-1:0] b);
        logic [DELTA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DELTA_W] ? DELTA_MAX : s[DELTA_W-1:0];
    endfunction

endpackage

// File: rtl/sine_sweep_next.sv
// Combinational next-point calculation for the sweep: one step toward stop,
// clamped so that neither overshoot nor underflow can pass the stop value.
module sine_sweep_next #(
    parameter int DW = 12
) (
    input  logic [DW-1:0] cur,
    input  logic [DW-1:0] stop,
    input  logic [DW-1:0] step,
    input  logic          up,
    output logic [DW-1:0] nxt,
    output logic          last
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    always_comb begin
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        nxt  = stop;
        if (up) begin
            if (sum <= {1'b0, stop})
                nxt = sum[DW-1:0];
        end else begin
            // diff[DW] set means the subtraction went below zero
            if (!diff[DW] && (diff[DW-1:0] >= stop))
                nxt = diff[DW-1:0];
        end
        last = (cur == stop);
    end

endmodule

// File: rtl/sine_sweep_ctrl.sv
// Sweeps the two-tone phase increments from start to stop, holding each point
// for a dwell time; one-shot or looped, with pause and abort.
module sine_sweep_ctrl
    import sine_ctrl_pkg::*;
#(
    parameter int DW = 12,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          pause,
    input  logic          cfg_loop,
    input  logic [DW-1:0] cfg_start_a,
    input  logic [DW-1:0] cfg_stop_a,
    input  logic [DW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_offset_b,
    input  logic [CW-1:0] cfg_dwell,
    output logic [DW-1:0] delta_a,
    output logic [DW-1:0] delta_b,
    output logic          delta_upd,
    output logic          busy,
    output logic          done,
    output logic          wrap,
    output logic [DW-1:0] step_idx
);

    state_t        state;
    logic [CW-1:0] cnt;

    // Configuration captured at start; a sweep never sees later cfg changes.
    logic [DW-1:0] sh_start;
    logic [DW-1:0] sh_stop;
    logic [DW-1:0] sh_step;
    logic [DW-1:0] sh_offset;
    logic [CW-1:0] sh_dwell_m1;
    logic          sh_loop;
    logic          sh_up;

    logic [DW-1:0] nxt_a;
    logic          at_last;

    sine_sweep_next #(.DW(DW)) u_next (
        .cur  (delta_a),
        .stop (sh_stop),
        .step (sh_step),
        .up   (sh_up),
        .nxt  (nxt_a),
        .last (at_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sh_start    <= '0;
            sh_stop     <= '0;
            sh_step     <= '0;
            sh_offset   <= '0;
            sh_dwell_m1 <= '0;
            sh_loop     <= 1'b0;
            sh_up       <= 1'b0;
            delta_a     <= '0;
            delta_b     <= '0;
            delta_upd   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wrap        <= 1'b0;
            step_idx    <= '0;
        end else begin
            delta_upd <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                busy      <= 1'b0;
                delta_a   <= '0;
                delta_b   <= '0;
                step_idx  <= '0;
                delta_upd <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            sh_start    <= cfg_start_a;
                            sh_stop     <= cfg_stop_a;
                            sh_step     <= (cfg_step == '0) ? DW'(1) : cfg_step;
                            sh_offset   <= cfg_offset_b;
                            sh_dwell_m1 <= (cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1;
                            sh_loop     <= cfg_loop;
                            sh_up       <= (cfg_stop_a >= cfg_start_a);
                            busy        <= 1'b1;
                            state       <= LOAD;
                        end
                    end
                    LOAD: begin
                        delta_a   <= sh_start;
                        delta_b   <= sat_add(sh_start, sh_offset);
                        delta_upd <= 1'b1;
                        step_idx  <= '0;
                        cnt       <= sh_dwell_m1;
                        state     <= DWELL;
                    end
                    DWELL, PAUSED: begin
                        // The counter is frozen exactly on cycles where pause is high.
                        if (pause) begin
                            state <= PAUSED;
                        end else begin
                            state <= DWELL;
                            if (cnt != '0) begin
                                cnt <= cnt - 1'b1;
                            end else if (at_last) begin
                                if (sh_loop) begin
                                    delta_a   <= sh_start;
                                    delta_b   <= sat_add(sh_start, sh_offset);
                                    delta_upd <= 1'b1;
                                    wrap      <= 1'b1;
                                    step_idx  <= '0;
                                    cnt       <= sh_dwell_m1;
                                end else begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end else begin
                                delta_a   <= nxt_a;
                                delta_b   <= sat_add(nxt_a, sh_offset);
                                delta_upd <= 1'b1;
                                step_idx  <= step_idx + 1'b1;
                                cnt       <= sh_dwell_m1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Bench for sine_sweep_ctrl: directed scenarios plus randomized one-shot sweeps
// compared against a point-list model of the sweep.
module tb_sine_sweep_ctrl;

    localparam int DW = 12;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, abort, pause, cfg_loop;
    logic [DW-1:0] cfg_start_a, cfg_stop_a, cfg_step, cfg_offset_b;
    logic [CW-1:0] cfg_dwell;
    logic [DW-1:0] delta_a, delta_b, step_idx;
    logic          delta_upd, busy, done, wrap;

    int checks   = 0;
    int failures = 0;
    int pts[$];

    sine_sweep_ctrl #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .cfg_loop(cfg_loop), .cfg_start_a(cfg_start_a), .cfg_stop_a(cfg_stop_a),
        .cfg_step(cfg_step), .cfg_offset_b(cfg_offset_b), .cfg_dwell(cfg_dwell),
        .delta_a(delta_a), .delta_b(delta_b), .delta_upd(delta_upd), .busy(busy),
        .done(done), .wrap(wrap), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic exp_out(input string tag, input int da, input int db, input int idx,
                           input int upd, input int bsy, input int dn, input int wr);
        chk({tag, "_delta_a"},   int'(delta_a),   da);
        chk({tag, "_delta_b"},   int'(delta_b),   db);
        chk({tag, "_step_idx"},  int'(step_idx),  idx);
        chk({tag, "_delta_upd"}, int'(delta_upd), upd);
        chk({tag, "_busy"},      int'(busy),      bsy);
        chk({tag, "_done"},      int'(done),      dn);
        chk({tag, "_wrap"},      int'(wrap),      wr);
    endtask

    function automatic int sat(input int a, input int b);
        return (a + b > 4095) ? 4095 : a + b;
    endfunction

    // Ordered list of delta_a values the sweep should visit.
    function automatic void build(input int s, input int e, input int st);
        int p;
        pts.delete();
        if (st == 0) st = 1;
        p = s;
        pts.push_back(p);
        while (p != e) begin
            if (e >= s) p = (p + st > e) ? e : p + st;
            else        p = (p - st < e) ? e : p - st;
            pts.push_back(p);
        end
    endfunction

    task automatic set_cfg(input int s, input int e, input int st, input int off,
                           input int dw, input int lp);
        cfg_start_a  = DW'(s);
        cfg_stop_a   = DW'(e);
        cfg_step     = DW'(st);
        cfg_offset_b = DW'(off);
        cfg_dwell    = CW'(dw);
        cfg_loop     = lp[0];
    endtask

    // Config noise and stray start pulses while busy must not disturb the sweep.
    task automatic scramble();
        cfg_start_a  = DW'($urandom);
        cfg_stop_a   = DW'($urandom);
        cfg_step     = DW'($urandom);
        cfg_offset_b = DW'($urandom);
        cfg_dwell    = CW'($urandom);
        cfg_loop     = 1'($urandom_range(0, 1));
        start        = 1'($urandom_range(0, 1));
    endtask

    task automatic run_oneshot(input string tag, input int s, input int e, input int st,
                               input int off, input int dw);
        int d;
        int last;
        d = (dw == 0) ? 1 : dw;
        build(s, e, st);
        set_cfg(s, e, st, off, dw, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_load_busy"}, int'(busy), 1);
        chk({tag, "_load_upd"},  int'(delta_upd), 0);
        for (int i = 0; i < pts.size(); i++) begin
            for (int c = 0; c < d; c++) begin
                scramble();
                tick();
                exp_out(tag, pts[i], sat(pts[i], off), i, (c == 0) ? 1 : 0, 1, 0, 0);
            end
        end
        start = 1'b0;
        last = pts.size() - 1;
        tick();
        exp_out({tag, "_done"}, pts[last], sat(pts[last], off), last, 0, 0, 1, 0);
        tick();
        exp_out({tag, "_idle"}, pts[last], sat(pts[last], off), last, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        exp_out("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        exp_out("idle_after_reset", 0, 0, 0, 0, 0, 0, 0);

        run_oneshot("up",     100, 130, 10, 50, 4);
        run_oneshot("down",   130, 100, 20, 0, 1);
        run_oneshot("sat",    4000, 4095, 100, 50, 2);
        run_oneshot("zero",   5, 7, 0, 0, 0);
        run_oneshot("single", 777, 777, 3, 9, 3);

        for (int r = 0; r < 6; r++) begin
            int s, e, span;
            s    = $urandom_range(0, 4095);
            span = $urandom_range(0, 300);
            if ($urandom_range(0, 1) == 1) e = (s + span > 4095) ? 4095 : s + span;
            else                           e = (s - span < 0) ? 0 : s - span;
            run_oneshot("rand", s, e, $urandom_range(0, 80), $urandom_range(0, 4095),
                        $urandom_range(0, 3));
        end

        // Loop with a 5-cycle pause on the second point, then abort.
        set_cfg(10, 30, 10, 0, 3, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_out("loop_p0", 10, 10, 0, (c == 0) ? 1 : 0, 1, 0, 0);
        end
        tick();
        exp_out("loop_p1", 20, 20, 1, 1, 1, 0, 0);
        pause = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            exp_out("loop_paused", 20, 20, 1, 0, 1, 0, 0);
        end
        pause = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            exp_out("loop_resumed", 20, 20, 1, 0, 1, 0, 0);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_out("loop_p2", 30, 30, 2, (c == 0) ? 1 : 0, 1, 0, 0);
        end
        tick();
        exp_out("loop_wrap", 10, 10, 0, 1, 1, 0, 1);
        tick();
        tick();
        tick();
        exp_out("loop_after_wrap", 20, 20, 1, 1, 1, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_out("loop_abort", 0, 0, 0, 1, 0, 0, 0);

        // Abort during the third point of a one-shot sweep.
        set_cfg(100, 130, 10, 50, 4, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        exp_out("abort_pre", 120, 170, 2, 0, 1, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_out("abort", 0, 0, 0, 1, 0, 0, 0);
        tick();
        exp_out("abort_idle", 0, 0, 0, 0, 0, 0, 0);

        // Start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        exp_out("start_abort", 0, 0, 0, 0, 0, 0, 0);
        tick();
        exp_out("start_abort_idle", 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a sweep.
        set_cfg(200, 300, 5, 7, 2, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        exp_out("pre_reset", 205, 212, 1, 1, 1, 0, 0);
        rst = 1'b1;
        tick();
        exp_out("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        exp_out("post_reset", 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
